// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// odd/even parity, STOP_BITS stop bits. Level-sensitive valid/ready handshake.
module uart_tx_param #(
    parameter int unsigned BAUD_DIV  = 434,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy_flag,
    output logic                 frame_done,
    output logic                 tx
);

    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam int unsigned CW = $clog2(DATA_BITS);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [BW-1:0]        r_baud_cnt;
    logic [CW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_frame_done;

    logic w_idle;
    logic w_baud_wrap;

    assign w_idle      = (r_state == S_IDLE);
    assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);

    assign tx_ready   = w_idle;
    assign busy_flag  = ~w_idle;
    assign frame_done = r_frame_done;
    assign tx         = r_tx;

    // r_tx is loaded with the value of the state being entered, so the line
    // changes on the same edge as the state and stays glitch-free.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (!w_idle) begin
                r_baud_cnt <= w_baud_wrap ? '0 : r_baud_cnt + BW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (tx_valid) begin
                        r_shift  <= data_in;
                        r_parity <= (PARITY == 1) ? ~(^data_in) : (^data_in);
                        r_tx     <= 1'b0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_baud_wrap) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_wrap) begin
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt    <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at BAUD_DIV=4,
// one selected at a time; expected line levels are hand-derived bit lists.
module tb_uart_tx_param;

    logic       sys_clk;
    logic       r_rst;
    logic       r_valid;
    logic [8:0] r_data;
    logic [1:0] r_sel;
    logic [3:0] w_valid;

    logic w_tx [4];
    logic w_ready [4];
    logic w_busy [4];
    logic w_done [4];

    int n_checks;
    int n_errors;

    assign w_valid = r_valid ? (4'b0001 << r_sel) : 4'b0000;

    uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .sys_clk(sys_clk), .rst(r_rst), .data_in(r_data[7:0]), .tx_valid(w_valid[0]),
        .tx_ready(w_ready[0]), .busy_flag(w_busy[0]), .frame_done(w_done[0]), .tx(w_tx[0]));
    uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .sys_clk(sys_clk), .rst(r_rst), .data_in(r_data[7:0]), .tx_valid(w_valid[1]),
        .tx_ready(w_ready[1]), .busy_flag(w_busy[1]), .frame_done(w_done[1]), .tx(w_tx[1]));
    uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .sys_clk(sys_clk), .rst(r_rst), .data_in(r_data[7:0]), .tx_valid(w_valid[2]),
        .tx_ready(w_ready[2]), .busy_flag(w_busy[2]), .frame_done(w_done[2]), .tx(w_tx[2]));
    uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .sys_clk(sys_clk), .rst(r_rst), .data_in(r_data[6:0]), .tx_valid(w_valid[3]),
        .tx_ready(w_ready[3]), .busy_flag(w_busy[3]), .frame_done(w_done[3]), .tx(w_tx[3]));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%b exp=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Presents a word at a falling edge, lets it be accepted, then changes data_in.
    task automatic start_frame(input logic [1:0] sel, input logic [8:0] word,
                               input logic [8:0] chg);
        @(negedge sys_clk);
        r_sel   = sel;
        r_valid = 1'b1;
        r_data  = word;
        check("ready_before_accept", w_ready[sel], 1'b1);
        @(posedge sys_clk);
        #1;
        r_valid = 1'b0;
        r_data  = chg;
    endtask

    // Checks every cycle of one frame from the cycle after acceptance, then the
    // frame_done cycle. inj_at >= 1 pulses tx_valid for 3 cycles mid-frame.
    task automatic check_frame(input logic [8:0] word, input int ndata, input int has_par,
                               input logic exp_par, input int nstop, input int inj_at);
        logic [15:0] bits;
        int          n;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < ndata; i++) bits[1+i] = word[i];
        if (has_par != 0) bits[1+ndata] = exp_par;
        n = 1 + ndata + has_par + nstop;
        for (int c = 1; c <= n * 4; c++) begin
            @(negedge sys_clk);
            if (c == inj_at) begin
                r_valid = 1'b1;
                r_data  = 9'h0FF;
            end
            if (inj_at > 0 && c == inj_at + 3) r_valid = 1'b0;
            check("frame_tx", w_tx[r_sel], bits[(c-1)/4]);
            check("frame_ready_low", w_ready[r_sel], 1'b0);
            check("frame_busy_high", w_busy[r_sel], 1'b1);
            check("frame_done_early", w_done[r_sel], 1'b0);
        end
        @(negedge sys_clk);
        check("done_pulse", w_done[r_sel], 1'b1);
        check("done_ready", w_ready[r_sel], 1'b1);
        check("done_tx_idle", w_tx[r_sel], 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        r_rst    = 1'b1;
        r_valid  = 1'b0;
        r_data   = '0;
        r_sel    = 2'd0;
        repeat (2) @(posedge sys_clk);

        // Reset state of every instance.
        @(negedge sys_clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_tx", w_tx[k], 1'b1);
            check("rst_ready", w_ready[k], 1'b1);
            check("rst_busy", w_busy[k], 1'b0);
            check("rst_done", w_done[k], 1'b0);
        end

        // Reset wins over a simultaneous handshake.
        r_sel   = 2'd0;
        r_valid = 1'b1;
        r_data  = 9'h055;
        @(posedge sys_clk);
        #1;
        r_rst   = 1'b0;
        r_valid = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            check("rst_prio_tx", w_tx[0], 1'b1);
            check("rst_prio_ready", w_ready[0], 1'b1);
        end

        // 8N1 0x55: line 0,1,0,1,0,1,0,1,0,1.
        start_frame(2'd0, 9'h055, 9'h000);
        check_frame(9'h055, 8, 0, 1'b0, 1, 0);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0.
        start_frame(2'd1, 9'h007, 9'h000);
        check_frame(9'h007, 8, 1, 1'b1, 1, 0);
        start_frame(2'd2, 9'h007, 9'h000);
        check_frame(9'h007, 8, 1, 1'b0, 1, 0);

        // 7N2 0x7F, data_in cleared right after acceptance.
        start_frame(2'd3, 9'h07F, 9'h000);
        check_frame(9'h07F, 7, 0, 1'b0, 2, 0);

        // Back-to-back with tx_valid held: second start bit 41 cycles after the first.
        @(negedge sys_clk);
        r_sel   = 2'd0;
        r_valid = 1'b1;
        r_data  = 9'h0A1;
        @(posedge sys_clk);
        #1;
        r_data = 9'h03C;
        check_frame(9'h0A1, 8, 0, 1'b0, 1, 0);
        @(posedge sys_clk);
        #1;
        r_valid = 1'b0;
        check_frame(9'h03C, 8, 0, 1'b0, 1, 0);

        // Reset during data bit 3 (cycles 17..20 after acceptance).
        start_frame(2'd0, 9'h055, 9'h000);
        repeat (18) @(negedge sys_clk);
        check("mid_bit3_tx", w_tx[0], 1'b0);
        r_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        r_rst = 1'b0;
        @(negedge sys_clk);
        check("abort_tx", w_tx[0], 1'b1);
        check("abort_ready", w_ready[0], 1'b1);
        repeat (30) begin
            check("abort_no_done", w_done[0], 1'b0);
            check("abort_tx_idle", w_tx[0], 1'b1);
            @(negedge sys_clk);
        end
        start_frame(2'd0, 9'h03C, 9'h0FF);
        check_frame(9'h03C, 8, 0, 1'b0, 1, 0);

        // tx_valid pulsed while busy and dropped: no second frame.
        start_frame(2'd0, 9'h0C3, 9'h000);
        check_frame(9'h0C3, 8, 0, 1'b0, 1, 10);
        repeat (20) begin
            @(negedge sys_clk);
            check("no_second_tx", w_tx[0], 1'b1);
            check("no_second_ready", w_ready[0], 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter BAUD_DIV, default 434, SHALL set the clock cycles per serial bit; legal range 2..65535 (434 = 115200 baud at 50 MHz).
REQ-002 Parameter DATA_BITS, default 8, SHALL set the number of data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, SHALL select the parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1, SHALL set the number of stop bits; legal values 1 or 2.
REQ-005 sys_clk  input  1  SHALL be the single clock; all logic is rising-edge triggered.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 data_in  input  DATA_BITS  SHALL carry the parallel word, sampled on handshake.
REQ-008 tx_valid  input  1  SHALL indicate that data_in holds a word to send.
REQ-009 tx_ready  output  1  SHALL be high when the block accepts a word this cycle.
REQ-010 busy_flag  output  1  SHALL be high while a frame is being shifted out.
REQ-011 frame_done  output  1  SHALL pulse high for one cycle when the last stop bit completes.
REQ-012 tx  output  1  SHALL be the serial line, idle high.

Function
REQ-013 Handshake: a word SHALL be accepted on any rising edge where tx_valid=1 and tx_ready=1; level-sensitive, so no edge detection on tx_valid.
REQ-014 tx_ready SHALL equal 1 only in state IDLE; busy_flag SHALL equal NOT tx_ready.
REQ-015 On acceptance, data_in SHALL be latched into an internal shift register, and later changes to data_in SHALL NOT affect the frame.
REQ-016 FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; PARITY is skipped when PARITY=0.
REQ-017 A baud counter SHALL count 0..BAUD_DIV-1 in every non-IDLE state, and each state/bit SHALL last exactly BAUD_DIV cycles.
REQ-018 Latency: tx SHALL go low (start bit) on the first rising edge after acceptance.
REQ-019 START SHALL drive tx=0 for one bit period.
REQ-020 DATA SHALL drive DATA_BITS bits, LSB first; a bit counter 0..DATA_BITS-1 SHALL advance on baud counter wrap.
REQ-021 PARITY SHALL drive the XOR of the latched data bits (even mode) or its inverse (odd mode).
REQ-022 STOP SHALL drive tx=1 for STOP_BITS bit periods.
REQ-023 frame_done SHALL assert in the cycle the FSM returns to IDLE.
REQ-024 Back-to-back: with tx_valid held high, the next word SHALL be accepted in the first IDLE cycle, giving a frame-to-frame period of (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV+1 cycles.
REQ-025 tx_valid asserted while busy SHALL be ignored until tx_ready=1, with no loss of the held word and no glitch on tx.
REQ-026 tx SHALL be driven from a register (glitch-free) and SHALL be 1 in IDLE.
REQ-027 Counter widths SHALL be sized from the parameters via $clog2, with no truncation at BAUD_DIV=65535.

Reset
REQ-028 While rst=1 at a rising edge: state=IDLE, tx=1, tx_ready=1, busy_flag=0, frame_done=0, and all counters and the shift register = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; tx=1 on the next edge, with no partial stop bit or frame_done pulse.
REQ-030 Reset SHALL take priority over a simultaneous handshake; the word presented that cycle is dropped.

Verification (BAUD_DIV=4 for simulation)
REQ-031 8N1, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; frame_done pulses at cycle 41 after acceptance; tx_ready low for 40 cycles.
REQ-032 8E1, send 0x07 (three ones) -> parity bit=1; 8O1, send 0x07 -> parity bit=0; each frame is 11 bits = 44 cycles.
REQ-033 7N2, send 0x7F with data_in changed to 0x00 the cycle after acceptance -> seven 1 data bits then two stop bits; the changed data_in has no effect.
REQ-034 tx_valid held high with words 0xA1 then 0x3C -> second start bit begins exactly 41 cycles after the first (8N1); both frames are bit-exact.
REQ-035 rst pulsed during DATA bit 3 -> tx=1 and tx_ready=1 on the next edge, and no frame_done; a new word is then accepted normally.
REQ-036 tx_valid pulsed while busy_flag=1 and dropped before IDLE -> no second frame, and tx stays 1 after the stop bit.
